// File: rtl/c_scan.sv
// Multi-cycle unary-code classifier: scans a P_W-bit word LSB-first, P_K bits per beat,
// through a chain of c_cell instances whose prior-state is carried in registers between beats.

module c_cell #(
   parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
   input  logic i_x,
   input  logic i_x_prev,
   input  logic i_is_first,
   input  logic i_all_ones,
   input  logic i_all_zeros_n,
   input  logic i_seen_edge,
   input  logic i_seen0,
   input  logic i_seen1,
   input  logic i_is_unary,
   input  logic i_is_unary_n,
   output logic o_all_ones,
   output logic o_all_zeros_n,
   output logic o_seen_edge,
   output logic o_seen0,
   output logic o_seen1,
   output logic o_is_unary,
   output logic o_is_unary_n
);
   logic en_n;
   logic edge_hit;

   assign en_n = (P_ADMIT_COMPLIMENT_EN != 0);

   always_comb begin
      edge_hit      = ~i_is_first & (i_x ^ i_x_prev);
      o_all_ones    = i_x;
      o_all_zeros_n = i_x;
      o_seen_edge   = 1'b0;
      o_seen0       = ~i_x;
      o_seen1       = i_x;
      o_is_unary    = i_x;
      o_is_unary_n  = ~i_x & en_n;
      if (!i_is_first) begin
         o_all_ones    = i_all_ones & i_x;
         o_all_zeros_n = i_all_zeros_n | i_x;
         o_seen_edge   = i_seen_edge | edge_hit;
         o_seen0       = i_seen0 | ~i_x;
         o_seen1       = i_seen1 | i_x;
         // A word that started on the right value stays unary until it flips a second time.
         o_is_unary    = i_is_unary & ~(edge_hit & i_seen_edge);
         o_is_unary_n  = i_is_unary_n & ~(edge_hit & i_seen_edge);
      end
   end
endmodule

module c_scan #(
   parameter int P_W                   = 32,
   parameter int P_K                   = 8,
   parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
   input  logic                       i_clk,
   input  logic                       i_arst,
   input  logic                       i_in_vld,
   output logic                       o_in_rdy,
   input  logic [P_W-1:0]             i_in_x,
   output logic                       o_out_vld,
   input  logic                       i_out_rdy,
   output logic                       o_out_is_unary,
   output logic                       o_out_is_unary_n,
   output logic                       o_out_all_ones,
   output logic                       o_out_all_zeros,
   output logic [$clog2(P_W+1)-1:0]   o_out_len
);
   localparam int N  = P_W / P_K;
   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam int LW = $clog2(P_W + 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [LW-1:0] LEN_ONE   = LW'(1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q, state_d;
   logic [P_W-1:0]  x_q, x_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [LW-1:0]   len_q, len_d;
   logic            xp_q, xp_d;
   logic            all_ones_q, all_ones_d, all_zeros_n_q, all_zeros_n_d;
   logic            seen_edge_q, seen_edge_d, seen0_q, seen0_d, seen1_q, seen1_d;
   logic            unary_q, unary_d, unary_n_q, unary_n_d;
   logic            r_unary_q, r_unary_d, r_unary_n_q, r_unary_n_d;
   logic            r_all_ones_q, r_all_ones_d, r_all_zeros_q, r_all_zeros_d;
   logic [LW-1:0]   r_len_q, r_len_d;

   logic [P_W-1:0]  shifted;
   logic [P_K-1:0]  beat_x;
   logic [LW-1:0]   cnt;
   logic [P_K-1:0]  ch_all_ones, ch_all_zeros_n, ch_seen_edge, ch_seen0, ch_seen1;
   logic [P_K-1:0]  ch_unary, ch_unary_n;

   assign shifted = x_q >> (P_K * int'(beat_q));
   assign beat_x  = shifted[P_K-1:0];

   for (genvar g = 0; g < P_K; g++) begin : g_cell
      if (g == 0) begin : g_head
         c_cell #(.P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)) u_cell (
            .i_x(beat_x[0]), .i_x_prev(xp_q), .i_is_first(beat_q == '0),
            .i_all_ones(all_ones_q), .i_all_zeros_n(all_zeros_n_q), .i_seen_edge(seen_edge_q),
            .i_seen0(seen0_q), .i_seen1(seen1_q), .i_is_unary(unary_q), .i_is_unary_n(unary_n_q),
            .o_all_ones(ch_all_ones[0]), .o_all_zeros_n(ch_all_zeros_n[0]),
            .o_seen_edge(ch_seen_edge[0]), .o_seen0(ch_seen0[0]), .o_seen1(ch_seen1[0]),
            .o_is_unary(ch_unary[0]), .o_is_unary_n(ch_unary_n[0]));
      end else begin : g_body
         c_cell #(.P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)) u_cell (
            .i_x(beat_x[g]), .i_x_prev(beat_x[g-1]), .i_is_first(1'b0),
            .i_all_ones(ch_all_ones[g-1]), .i_all_zeros_n(ch_all_zeros_n[g-1]),
            .i_seen_edge(ch_seen_edge[g-1]), .i_seen0(ch_seen0[g-1]), .i_seen1(ch_seen1[g-1]),
            .i_is_unary(ch_unary[g-1]), .i_is_unary_n(ch_unary_n[g-1]),
            .o_all_ones(ch_all_ones[g]), .o_all_zeros_n(ch_all_zeros_n[g]),
            .o_seen_edge(ch_seen_edge[g]), .o_seen0(ch_seen0[g]), .o_seen1(ch_seen1[g]),
            .o_is_unary(ch_unary[g]), .o_is_unary_n(ch_unary_n[g]));
      end
   end

   // Bits of this beat that precede its first edge; only used while no edge is carried in.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < P_K; i++) begin
         if (!ch_seen_edge[i]) cnt = cnt + LEN_ONE;
      end
   end

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      beat_d        = beat_q;
      len_d         = len_q;
      xp_d          = xp_q;
      all_ones_d    = all_ones_q;
      all_zeros_n_d = all_zeros_n_q;
      seen_edge_d   = seen_edge_q;
      seen0_d       = seen0_q;
      seen1_d       = seen1_q;
      unary_d       = unary_q;
      unary_n_d     = unary_n_q;
      r_unary_d     = r_unary_q;
      r_unary_n_d   = r_unary_n_q;
      r_all_ones_d  = r_all_ones_q;
      r_all_zeros_d = r_all_zeros_q;
      r_len_d       = r_len_q;
      o_in_rdy      = 1'b0;
      o_out_vld     = 1'b0;
      case (state_q)
         IDLE: o_in_rdy = 1'b1;
         SCAN: begin
            xp_d          = beat_x[P_K-1];
            all_ones_d    = ch_all_ones[P_K-1];
            all_zeros_n_d = ch_all_zeros_n[P_K-1];
            seen_edge_d   = ch_seen_edge[P_K-1];
            seen0_d       = ch_seen0[P_K-1];
            seen1_d       = ch_seen1[P_K-1];
            unary_d       = ch_unary[P_K-1];
            unary_n_d     = ch_unary_n[P_K-1];
            if (!seen_edge_q) len_d = len_q + cnt;
            beat_d = beat_q + BEAT_ONE;
            if (beat_q == BEAT_LAST) begin
               r_unary_d     = ch_unary[P_K-1];
               r_unary_n_d   = ch_unary_n[P_K-1];
               r_all_ones_d  = ch_all_ones[P_K-1] & ~ch_seen0[P_K-1];
               r_all_zeros_d = ~ch_all_zeros_n[P_K-1] & ~ch_seen1[P_K-1];
               r_len_d       = seen_edge_q ? len_q : len_q + cnt;
               beat_d        = '0;
               state_d       = DONE;
            end
         end
         DONE: begin
            o_out_vld = 1'b1;
            o_in_rdy  = i_out_rdy;
            if (i_out_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (o_in_rdy && i_in_vld) begin
         x_d           = i_in_x;
         beat_d        = '0;
         len_d         = '0;
         xp_d          = 1'b0;
         all_ones_d    = 1'b0;
         all_zeros_n_d = 1'b0;
         seen_edge_d   = 1'b0;
         seen0_d       = 1'b0;
         seen1_d       = 1'b0;
         unary_d       = 1'b0;
         unary_n_d     = 1'b0;
         state_d       = SCAN;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         beat_q        <= '0;
         len_q         <= '0;
         xp_q          <= 1'b0;
         all_ones_q    <= 1'b0;
         all_zeros_n_q <= 1'b0;
         seen_edge_q   <= 1'b0;
         seen0_q       <= 1'b0;
         seen1_q       <= 1'b0;
         unary_q       <= 1'b0;
         unary_n_q     <= 1'b0;
         r_unary_q     <= 1'b0;
         r_unary_n_q   <= 1'b0;
         r_all_ones_q  <= 1'b0;
         r_all_zeros_q <= 1'b0;
         r_len_q       <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         beat_q        <= beat_d;
         len_q         <= len_d;
         xp_q          <= xp_d;
         all_ones_q    <= all_ones_d;
         all_zeros_n_q <= all_zeros_n_d;
         seen_edge_q   <= seen_edge_d;
         seen0_q       <= seen0_d;
         seen1_q       <= seen1_d;
         unary_q       <= unary_d;
         unary_n_q     <= unary_n_d;
         r_unary_q     <= r_unary_d;
         r_unary_n_q   <= r_unary_n_d;
         r_all_ones_q  <= r_all_ones_d;
         r_all_zeros_q <= r_all_zeros_d;
         r_len_q       <= r_len_d;
      end
   end

   assign o_out_is_unary   = r_unary_q;
   assign o_out_is_unary_n = r_unary_n_q;
   assign o_out_all_ones   = r_all_ones_q;
   assign o_out_all_zeros  = r_all_zeros_q;
   assign o_out_len        = r_len_q;
endmodule

// File: tb/tb_c_scan.sv
// Directed bench for c_scan: two instances (complement detection on/off) share one stimulus stream;
// every result is compared against hand-computed values.

module tb_c_scan;
   logic        clk;
   logic        i_arst;
   logic        i_in_vld;
   logic [31:0] i_in_x;
   logic        i_out_rdy;
   logic        in_rdy, out_vld, is_u, is_un, all1, all0;
   logic [5:0]  len;
   logic        in_rdy_nc, out_vld_nc, is_u_nc, is_un_nc, all1_nc, all0_nc;
   logic [5:0]  len_nc;
   int          checks = 0;
   int          errors = 0;

   c_scan #(.P_W(32), .P_K(8), .P_ADMIT_COMPLIMENT_EN(1)) dut (
      .i_clk(clk), .i_arst(i_arst), .i_in_vld(i_in_vld), .o_in_rdy(in_rdy), .i_in_x(i_in_x),
      .o_out_vld(out_vld), .i_out_rdy(i_out_rdy), .o_out_is_unary(is_u), .o_out_is_unary_n(is_un),
      .o_out_all_ones(all1), .o_out_all_zeros(all0), .o_out_len(len));

   c_scan #(.P_W(32), .P_K(8), .P_ADMIT_COMPLIMENT_EN(0)) dut_nc (
      .i_clk(clk), .i_arst(i_arst), .i_in_vld(i_in_vld), .o_in_rdy(in_rdy_nc), .i_in_x(i_in_x),
      .o_out_vld(out_vld_nc), .i_out_rdy(i_out_rdy), .o_out_is_unary(is_u_nc),
      .o_out_is_unary_n(is_un_nc), .o_out_all_ones(all1_nc), .o_out_all_zeros(all0_nc),
      .o_out_len(len_nc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic u, input logic un, input logic ao,
                             input logic az, input logic [5:0] l);
      chk({tag, " vld"}, out_vld, 1);
      chk({tag, " is_unary"}, is_u, u);
      chk({tag, " is_unary_n"}, is_un, un);
      chk({tag, " all_ones"}, all1, ao);
      chk({tag, " all_zeros"}, all0, az);
      chk({tag, " len"}, len, l);
      chk({tag, " nc is_unary_n"}, is_un_nc, 0);
      chk({tag, " nc is_unary"}, is_u_nc, u);
      chk({tag, " nc len"}, len_nc, l);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
   task automatic run_word(input string tag, input logic [31:0] x, input logic u, input logic un,
                           input logic ao, input logic az, input logic [5:0] l);
      i_in_vld  = 1'b1;
      i_in_x    = x;
      i_out_rdy = 1'b0;
      chk({tag, " in_rdy idle"}, in_rdy, 1);
      @(posedge clk); #1;
      i_in_vld = 1'b0;
      i_in_x   = $urandom;
      chk({tag, " in_rdy scan"}, in_rdy, 0);
      repeat (3) @(posedge clk);
      #1 chk({tag, " vld early"}, out_vld, 0);
      @(posedge clk); #1;
      chk_result(tag, u, un, ao, az, l);
      i_out_rdy = 1'b1;
      @(posedge clk); #1;
      i_out_rdy = 1'b0;
      chk({tag, " vld after pop"}, out_vld, 0);
      chk({tag, " in_rdy after pop"}, in_rdy, 1);
   endtask

   initial begin
      i_arst    = 1'b1;
      i_in_vld  = 1'b0;
      i_in_x    = '0;
      i_out_rdy = 1'b0;
      #12;
      chk("reset in_rdy", in_rdy, 1);
      chk("reset vld", out_vld, 0);
      chk("reset len", len, 0);
      chk("reset is_unary", is_u, 0);
      chk("reset all_ones", all1, 0);
      @(posedge clk); #1;
      i_arst = 1'b0;
      @(posedge clk); #1;

      run_word("w00ff",     32'h0000_00FF, 1, 0, 0, 0, 6'd8);
      run_word("wff00",     32'hFFFF_FF00, 0, 1, 0, 0, 6'd8);
      run_word("wffff",     32'hFFFF_FFFF, 1, 0, 1, 0, 6'd32);
      run_word("w0000",     32'h0000_0000, 0, 1, 0, 1, 6'd32);
      run_word("w01ff",     32'h0000_01FF, 1, 0, 0, 0, 6'd9);
      run_word("w0f0f",     32'h0000_0F0F, 0, 0, 0, 0, 6'd4);
      run_word("w8000",     32'h8000_0000, 0, 1, 0, 0, 6'd31);
      run_word("w7fff",     32'h7FFF_FFFF, 1, 0, 0, 0, 6'd31);

      // Backpressure, then same-edge handoff to a new word.
      i_in_vld = 1'b1;
      i_in_x   = 32'h0000_00FF;
      @(posedge clk); #1;
      i_in_vld = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk_result("bp first", 1, 0, 0, 0, 6'd8);
      i_in_vld = 1'b1;
      i_in_x   = 32'h0000_01FF;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp vld held", out_vld, 1);
         chk("bp len held", len, 8);
         chk("bp unary held", is_u, 1);
         chk("bp in_rdy", in_rdy, 0);
      end
      i_out_rdy = 1'b1;
      #1 chk("handoff in_rdy", in_rdy, 1);
      @(posedge clk); #1;
      i_out_rdy = 1'b0;
      i_in_vld  = 1'b0;
      chk("handoff vld drop", out_vld, 0);
      chk("handoff in_rdy scan", in_rdy, 0);
      repeat (3) @(posedge clk);
      #1 chk("handoff vld early", out_vld, 0);
      @(posedge clk); #1;
      chk_result("handoff second", 1, 0, 0, 0, 6'd9);
      i_out_rdy = 1'b1;
      @(posedge clk); #1;
      i_out_rdy = 1'b0;

      // Reset during beat 2 of a scan.
      i_in_vld = 1'b1;
      i_in_x   = 32'hFFFF_FF00;
      @(posedge clk); #1;
      i_in_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1 i_arst = 1'b1;
      #1 chk("rst scan vld", out_vld, 0);
      chk("rst scan in_rdy", in_rdy, 1);
      @(posedge clk); #1;
      i_arst = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("rst scan no output", out_vld, 0);
      chk("rst scan len", len, 0);
      run_word("post rst", 32'h0000_0F0F, 0, 0, 0, 0, 6'd4);

      // Reset while a result is presented drops valid at once.
      i_in_vld = 1'b1;
      i_in_x   = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      i_in_vld = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("done vld", out_vld, 1);
      i_arst = 1'b1;
      #1 chk("rst done vld", out_vld, 0);
      chk("rst done all_ones", all1, 0);
      chk("rst done len", len, 0);
      @(posedge clk); #1;
      i_arst = 1'b0;
      @(posedge clk); #1;
      run_word("post rst2", 32'h0000_0001, 1, 0, 0, 0, 6'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
